// File: rtl/irq_ctx_pkg.sv
// Shared types and defaults for the interrupt context save/restore controller.
// The optional flag save/restore path is enabled by defining IRQ_FLAG_SAVE_EN.
package irq_ctx_pkg;

    localparam logic [31:0] VectorAddrDefault = 32'h0000_0100;
    localparam logic [3:0]  PcRegDefault      = 4'd12;
    localparam logic [3:0]  FlagRegDefault    = 4'd13;

    typedef enum logic [2:0] {
        StIdle,
        StSavePc,
        StSaveFlg,
        StJump,
        StIsr,
        StRestore
    } state_e;

    typedef enum logic [1:0] {
        WselCore,
        WselPc,
        WselFlg,
        WselNone
    } wsel_e;

    typedef struct packed {
        logic  stall;
        logic  jump;
        logic  isr;
        logic  restore;
        wsel_e wsel;
    } st_outs_t;

    // Moore outputs for a state; the all-zero value is also the reset value.
    function automatic st_outs_t state_outs(input state_e st);
        st_outs_t o;
        o = '0;
        case (st)
            StSavePc: begin
                o.stall = 1'b1;
                o.wsel  = WselPc;
            end
            StSaveFlg: begin
                o.stall = 1'b1;
                o.wsel  = WselFlg;
            end
            StJump: begin
                o.stall = 1'b1;
                o.jump  = 1'b1;
                o.wsel  = WselNone;
            end
            StIsr:     o.isr = 1'b1;
            StRestore: o.restore = 1'b1;
            default:   ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/irq_ctx_wport_mux.sv
// Register-file write port selection between core writeback and context save writes.
// block_i forces the write enable low regardless of the selected source.
module irq_ctx_wport_mux
    import irq_ctx_pkg::*;
#(
    parameter logic [3:0] PC_REG   = PcRegDefault,
    parameter logic [3:0] FLAG_REG = FlagRegDefault
) (
    input  wsel_e       wsel_i,
    input  logic        block_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_rd_i,
    input  logic [31:0] core_data_i,
    input  logic [31:0] pc_cap_i,
    input  logic [1:0]  flags_cap_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    always_comb begin
        rf_we_o    = core_we_i;
        rf_waddr_o = core_rd_i;
        rf_wdata_o = core_data_i;
        case (wsel_i)
            WselPc: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = PC_REG;
                rf_wdata_o = pc_cap_i;
            end
            WselFlg: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = FLAG_REG;
                rf_wdata_o = {30'b0, flags_cap_i};
            end
            WselNone: rf_we_o = 1'b0;
            default:  ;
        endcase
        if (block_i) begin
            rf_we_o = 1'b0;
        end
    end

endmodule

// File: rtl/irq_ctx_ctrl.sv
// Interrupt entry/exit controller: saves PC (and flags when IRQ_FLAG_SAVE_EN is defined)
// through the register-file write port, vectors to the ISR and restores on reti.
module irq_ctx_ctrl
    import irq_ctx_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR = VectorAddrDefault,
    parameter logic [3:0]  PC_REG      = PcRegDefault,
    parameter logic [3:0]  FLAG_REG    = FlagRegDefault
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        irq_i,
    input  logic        reti_i,
    input  logic [31:0] pc_in_i,
    input  logic [1:0]  flags_in_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_rd_i,
    input  logic [31:0] core_data_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        core_stall_o,
    output logic        pc_sel_o,
    output logic [31:0] pc_next_o,
    output logic        irq_ack_o,
    output logic        in_isr_o,
    output logic        flags_rst_valid_o,
    output logic [1:0]  flags_rst_o
);

    state_e      state_q, state_d;
    st_outs_t    outs_q;
    logic [31:0] pc_cap_q;
    logic [1:0]  flags_cap_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (irq_i) state_d = StSavePc;
`ifdef IRQ_FLAG_SAVE_EN
            StSavePc:  state_d = StSaveFlg;
`else
            StSavePc:  state_d = StJump;
`endif
            StSaveFlg: state_d = StJump;
            StJump:    state_d = StIsr;
            StIsr:     if (reti_i) state_d = StRestore;
            StRestore: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            outs_q      <= '0;
            pc_cap_q    <= '0;
            flags_cap_q <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= state_outs(state_d);
            if (state_q == StIdle && irq_i) begin
                pc_cap_q    <= pc_in_i;
                flags_cap_q <= flags_in_i;
            end
        end
    end

    irq_ctx_wport_mux #(
        .PC_REG   (PC_REG),
        .FLAG_REG (FLAG_REG)
    ) u_wport_mux (
        .wsel_i      (outs_q.wsel),
        .block_i     (rst_i),
        .core_we_i   (core_we_i),
        .core_rd_i   (core_rd_i),
        .core_data_i (core_data_i),
        .pc_cap_i    (pc_cap_q),
        .flags_cap_i (flags_cap_q),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o)
    );

    assign core_stall_o = outs_q.stall;
    assign pc_sel_o     = outs_q.jump | outs_q.restore;
    assign pc_next_o    = outs_q.jump    ? VECTOR_ADDR :
                          outs_q.restore ? pc_cap_q    : 32'h0;
    assign irq_ack_o    = outs_q.jump;
    assign in_isr_o     = outs_q.isr;

`ifdef IRQ_FLAG_SAVE_EN
    assign flags_rst_valid_o = outs_q.restore;
    assign flags_rst_o       = outs_q.restore ? flags_cap_q : 2'b00;
`else
    assign flags_rst_valid_o = 1'b0;
    assign flags_rst_o       = 2'b00;
`endif

endmodule

// File: tb/tb_irq_ctx_ctrl.sv
// Self-checking bench for irq_ctx_ctrl: directed entry/return/abort scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_irq_ctx_ctrl;

`ifdef IRQ_FLAG_SAVE_EN
    localparam bit FlagEn = 1'b1;
`else
    localparam bit FlagEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, irq, reti, core_we;
    logic [3:0]  core_rd;
    logic [31:0] core_data, pc_in;
    logic [1:0]  flags_in;
    logic        rf_we, core_stall, pc_sel, irq_ack, in_isr, frv;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata, pc_next;
    logic [1:0]  flags_rst;

    int checks = 0;
    int errors = 0;

    // Model: pending save actions (1 = PC write, 2 = flag write, 3 = vector jump).
    int          m_q[$];
    bit          m_isr, m_rest;
    logic [31:0] m_pc;
    logic [1:0]  m_fl;

    always #5 clk = ~clk;

    irq_ctx_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .irq_i             (irq),
        .reti_i            (reti),
        .pc_in_i           (pc_in),
        .flags_in_i        (flags_in),
        .core_we_i         (core_we),
        .core_rd_i         (core_rd),
        .core_data_i       (core_data),
        .rf_we_o           (rf_we),
        .rf_waddr_o        (rf_waddr),
        .rf_wdata_o        (rf_wdata),
        .core_stall_o      (core_stall),
        .pc_sel_o          (pc_sel),
        .pc_next_o         (pc_next),
        .irq_ack_o         (irq_ack),
        .in_isr_o          (in_isr),
        .flags_rst_valid_o (frv),
        .flags_rst_o       (flags_rst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic        e_we, e_stall, e_psel, e_ack, e_isr, e_frv;
        logic [3:0]  e_addr;
        logic [31:0] e_data, e_pnext;
        logic [1:0]  e_fl;
        e_we = core_we; e_addr = core_rd; e_data = core_data;
        e_stall = 0; e_psel = 0; e_ack = 0; e_isr = 0; e_frv = 0;
        e_pnext = 0; e_fl = 0;
        if (rst) begin
            e_we = 0;
        end else if (m_q.size() > 0) begin
            e_stall = 1;
            case (m_q[0])
                1:       begin e_we = 1; e_addr = 4'd12; e_data = m_pc; end
                2:       begin e_we = 1; e_addr = 4'd13; e_data = {30'b0, m_fl}; end
                default: begin e_we = 0; e_psel = 1; e_pnext = 32'h100; e_ack = 1; end
            endcase
        end else if (m_rest) begin
            e_psel = 1; e_pnext = m_pc; e_frv = FlagEn; e_fl = m_fl;
        end else begin
            e_isr = m_isr;
        end
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
            chk("rf_waddr", rf_waddr, e_addr);
            chk("rf_wdata", rf_wdata, e_data);
        end
        chk("core_stall", core_stall, e_stall);
        chk("pc_sel", pc_sel, e_psel);
        if (e_psel) chk("pc_next", pc_next, e_pnext);
        chk("irq_ack", irq_ack, e_ack);
        chk("in_isr", in_isr, e_isr);
        chk("flags_rst_valid", frv, e_frv);
        if (e_frv) chk("flags_rst", flags_rst, e_fl);
    endtask

    task automatic drive(input bit r, input bit i, input bit rt, input bit we,
                         input logic [3:0] rd, input logic [31:0] d,
                         input logic [31:0] pc, input logic [1:0] fl);
        @(negedge clk);
        rst = r; irq = i; reti = rt; core_we = we; core_rd = rd; core_data = d;
        pc_in = pc; flags_in = fl;
        #1;
        model_compare();
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_q.delete(); m_isr = 0; m_rest = 0; m_pc = 0; m_fl = 0;
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_isr = 1;
        end else if (m_rest) begin
            m_rest = 0;
        end else if (m_isr) begin
            if (reti) begin m_isr = 0; m_rest = 1; end
        end else if (irq) begin
            m_pc = pc_in; m_fl = flags_in;
            m_q.push_back(1);
`ifdef IRQ_FLAG_SAVE_EN
            m_q.push_back(2);
`endif
            m_q.push_back(3);
        end
    endtask

    initial begin
        rst = 1; irq = 0; reti = 0; core_we = 0; core_rd = 0; core_data = 0;
        pc_in = 0; flags_in = 0;

        // Reset state, with a core write that must be blocked.
        drive(1, 0, 0, 1, 4'd2, 32'h55, 0, 0);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_in_isr", in_isr, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Entry with a colliding core write in the irq cycle.
        drive(0, 1, 0, 1, 4'd3, 32'h7, 32'h40, 2'b10);
        chk("collide_we", rf_we, 1);
        chk("collide_addr", rf_waddr, 3);
        chk("collide_data", rf_wdata, 7);
        chk("collide_stall", core_stall, 0);
        step();
        drive(0, 0, 0, 1, 4'd5, 32'h9, 32'h44, 2'b01);
        chk("save_pc_addr", rf_waddr, 12);
        chk("save_pc_data", rf_wdata, 32'h40);
        chk("save_pc_stall", core_stall, 1);
        step();
`ifdef IRQ_FLAG_SAVE_EN
        drive(0, 0, 0, 1, 4'd5, 32'h9, 32'h48, 2'b01);
        chk("save_flg_addr", rf_waddr, 13);
        chk("save_flg_data", rf_wdata, 32'h2);
        chk("save_flg_stall", core_stall, 1);
        step();
`endif
        drive(0, 0, 0, 1, 4'd5, 32'h9, 32'h4c, 2'b01);
        chk("jump_we", rf_we, 0);
        chk("jump_pc_sel", pc_sel, 1);
        chk("jump_pc_next", pc_next, 32'h100);
        chk("jump_ack", irq_ack, 1);
        chk("jump_stall", core_stall, 1);
        step();

        // ISR with irq held high: no nesting, writes pass through.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 1, 4'd4, 32'h8, 32'h100, 2'b00);
            chk("isr_no_ack", irq_ack, 0);
            chk("isr_flag", in_isr, 1);
            chk("isr_stall", core_stall, 0);
            chk("isr_pass_addr", rf_waddr, 4);
            step();
        end
        drive(0, 0, 1, 0, 0, 0, 32'h104, 2'b00); step();
        drive(0, 0, 0, 1, 4'd6, 32'h1, 32'h108, 2'b00);
        chk("ret_pc_sel", pc_sel, 1);
        chk("ret_pc_next", pc_next, 32'h40);
        chk("ret_frv", frv, FlagEn);
        chk("ret_we_pass", rf_we, 1);
        step();
        // Spurious reti in IDLE.
        drive(0, 0, 1, 0, 0, 0, 32'h50, 2'b00);
        chk("spurious_reti", pc_sel, 0);
        step();

        // Reset abort inside the save sequence.
        drive(0, 1, 0, 0, 0, 0, 32'h80, 2'b11); step();
`ifdef IRQ_FLAG_SAVE_EN
        drive(0, 0, 0, 0, 0, 0, 32'h84, 2'b11); step();
`endif
        drive(1, 0, 0, 1, 4'd9, 32'h99, 32'h88, 2'b11);
        chk("abort_we", rf_we, 0);
        chk("abort_in_isr", in_isr, 0);
        chk("abort_stall", core_stall, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("abort_idle_stall", core_stall, 0);
        step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), $urandom, $urandom, 2'($urandom_range(0, 3)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
